// File: rtl/i4004_addr_stack_pkg.sv
// Shared MCS-4 types: address, instruction subcycle and stack command encodings.
package mcs4;

    typedef logic [11:0] addr_t;

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } instr_cyc_t;

    typedef enum logic [2:0] {
        NOP     = 3'd0,
        JUMP    = 3'd1,
        CALL    = 3'd2,
        RET     = 3'd3,
        LOAD_LO = 3'd4
    } stk_cmd_t;

    localparam int unsigned STACK_DEPTH = 4;

endpackage

// File: rtl/i4004_addr_stack_if.sv
// Bus between timing/decoder (master) and the address stack (slave).
interface i4004_addr_stack_if #(
    parameter int unsigned DEPTH = mcs4::STACK_DEPTH,
    parameter int unsigned AW    = 12
);
    import mcs4::*;

    instr_cyc_t               icyc;
    logic                     cyc_adv;
    stk_cmd_t                 cmd;
    logic                     cmd_valid;
    logic [AW-1:0]            load_addr;
    logic                     inc_hold;
    logic [3:0]               addr_nibble;
    logic                     addr_valid;
    logic [AW-1:0]            pc;
    logic [$clog2(DEPTH)-1:0] sp;
    logic                     stk_err;

    modport master (
        output icyc, cyc_adv, cmd, cmd_valid, load_addr, inc_hold,
        input  addr_nibble, addr_valid, pc, sp, stk_err
    );

    modport slave (
        input  icyc, cyc_adv, cmd, cmd_valid, load_addr, inc_hold,
        output addr_nibble, addr_valid, pc, sp, stk_err
    );

endinterface

// File: rtl/i4004_addr_stack.sv
// i4004 program counter / subroutine stack.
// Optional macro I4004_STACK_CHK_EN adds a depth counter and sticky stk_err.
module i4004_addr_stack
    import mcs4::*;
#(
    parameter int unsigned DEPTH = STACK_DEPTH,
    parameter int unsigned AW    = 12
) (
    input logic               clk,
    input logic               rst,
    i4004_addr_stack_if.slave bus
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] slot [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_up;
    logic [PW-1:0] ptr_dn;
    logic [AW-1:0] pc_q;
    logic          inc_en;
    logic          cmd_en;

    assign pc_q   = slot[ptr];
    assign ptr_up = ptr + PW'(1);
    assign ptr_dn = ptr - PW'(1);
    assign inc_en = bus.cyc_adv && (bus.icyc == A3) && !bus.inc_hold;
    assign cmd_en = bus.cyc_adv && (bus.icyc == X3) && bus.cmd_valid;

    assign bus.pc = pc_q;
    assign bus.sp = ptr;

    // Present the PC nibble for the current A-subcycle to the bus arbiter.
    always_comb begin
        bus.addr_nibble = 4'h0;
        bus.addr_valid  = 1'b0;
        case (bus.icyc)
            A1: begin bus.addr_nibble = pc_q[3:0];  bus.addr_valid = 1'b1; end
            A2: begin bus.addr_nibble = pc_q[7:4];  bus.addr_valid = 1'b1; end
            A3: begin bus.addr_nibble = pc_q[11:8]; bus.addr_valid = 1'b1; end
            default: ;
        endcase
    end

    // Slot file and pointer: A3 increment and X3 command execution.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot <= '{default: '0};
            ptr  <= '0;
        end else if (inc_en) begin
            slot[ptr] <= pc_q + AW'(1);
        end else if (cmd_en) begin
            case (bus.cmd)
                JUMP:    slot[ptr] <= bus.load_addr;
                CALL: begin
                    ptr          <= ptr_up;
                    slot[ptr_up] <= bus.load_addr;
                end
                RET:     ptr <= ptr_dn;
                LOAD_LO: slot[ptr][7:0] <= bus.load_addr[7:0];
                default: ;
            endcase
        end
    end

`ifdef I4004_STACK_CHK_EN
    logic [PW-1:0] depth;
    logic          err;

    // Saturating nesting depth; any CALL past full or RET past empty latches err.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth <= '0;
            err   <= 1'b0;
        end else if (cmd_en) begin
            case (bus.cmd)
                CALL: begin
                    if (depth == PW'(DEPTH - 1)) err <= 1'b1;
                    else                         depth <= depth + PW'(1);
                end
                RET: begin
                    if (depth == '0) err <= 1'b1;
                    else             depth <= depth - PW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.stk_err = err;
`else
    assign bus.stk_err = 1'b0;
`endif

endmodule

// File: tb/tb_i4004_addr_stack.sv
// Directed table-driven bench for i4004_addr_stack.
module tb_i4004_addr_stack;
    import mcs4::*;

`ifdef I4004_STACK_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    i4004_addr_stack_if #(.DEPTH(4), .AW(12)) bus ();

    i4004_addr_stack #(.DEPTH(4), .AW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        v;
        logic [2:0]  cmd;
        logic [11:0] la;
        logic        hold;
        logic [11:0] nibs;   // {A3,A2,A1}
        logic [11:0] m1;
        logic [11:0] pc_end;
        logic [1:0]  sp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full instruction cycle, two clks per subcycle; decoys outside A3/X3.
    task automatic run_instr(input logic v, input logic [2:0] c, input logic [11:0] la,
                             input logic hold, output logic [11:0] nibs, output logic [11:0] pc_m1);
        nibs  = '0;
        pc_m1 = '0;
        for (int k = 0; k < 8; k++) begin
            bus.icyc    = instr_cyc_t'(k);
            bus.cyc_adv = 1'b0;
            if (k == 7) begin
                bus.cmd_valid = v;
                bus.cmd       = stk_cmd_t'(c);
                bus.load_addr = la;
            end else begin
                bus.cmd_valid = 1'b1;
                bus.cmd       = JUMP;
                bus.load_addr = 12'hEEE;
            end
            bus.inc_hold = (k == 2) ? hold : 1'b1;
            @(posedge clk); #1;
            check("addr_valid", bus.addr_valid, (k < 3) ? 1 : 0);
            if (k < 3) nibs[k*4 +: 4] = bus.addr_nibble;
            else       check("nibble_idle", bus.addr_nibble, 0);
            if (k == 3) pc_m1 = bus.pc;
            bus.cyc_adv = 1'b1;
            @(posedge clk); #1;
            bus.cyc_adv = 1'b0;
        end
        bus.cmd_valid = 1'b0;
    endtask

    logic [11:0] nibs, m1;
    logic [11:0] call_la  [4] = '{12'h100, 12'h200, 12'h300, 12'h400};
    logic [11:0] ret_pc   [5] = '{12'h301, 12'h201, 12'h101, 12'h401, 12'h302};
    logic [1:0]  ret_sp   [5] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 12'h000, 1'b0, 12'h000, 12'h001, 12'h001, 2'd0};
        vecs[1]  = '{1'b0, 3'd0, 12'h000, 1'b0, 12'h001, 12'h002, 12'h002, 2'd0};
        vecs[2]  = '{1'b0, 3'd0, 12'h000, 1'b0, 12'h002, 12'h003, 12'h003, 2'd0};
        vecs[3]  = '{1'b1, 3'd1, 12'hFFF, 1'b0, 12'h003, 12'h004, 12'hFFF, 2'd0};
        vecs[4]  = '{1'b0, 3'd0, 12'h000, 1'b0, 12'hFFF, 12'h000, 12'h000, 2'd0};
        vecs[5]  = '{1'b1, 3'd1, 12'h123, 1'b0, 12'h000, 12'h001, 12'h123, 2'd0};
        vecs[6]  = '{1'b1, 3'd2, 12'h5A0, 1'b0, 12'h123, 12'h124, 12'h5A0, 2'd1};
        vecs[7]  = '{1'b1, 3'd3, 12'h000, 1'b0, 12'h5A0, 12'h5A1, 12'h124, 2'd0};
        vecs[8]  = '{1'b1, 3'd1, 12'h3F7, 1'b0, 12'h124, 12'h125, 12'h3F7, 2'd0};
        vecs[9]  = '{1'b1, 3'd4, 12'hAB2, 1'b0, 12'h3F7, 12'h3F8, 12'h3B2, 2'd0};
        vecs[10] = '{1'b0, 3'd0, 12'h000, 1'b1, 12'h3B2, 12'h3B2, 12'h3B2, 2'd0};
        vecs[11] = '{1'b1, 3'd5, 12'h777, 1'b0, 12'h3B2, 12'h3B3, 12'h3B3, 2'd0};
        vecs[12] = '{1'b0, 3'd1, 12'h555, 1'b0, 12'h3B3, 12'h3B4, 12'h3B4, 2'd0};

        bus.icyc      = A1;
        bus.cyc_adv   = 1'b1;
        bus.cmd       = NOP;
        bus.cmd_valid = 1'b0;
        bus.load_addr = '0;
        bus.inc_hold  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.cyc_adv = 1'b0;
        check("reset_pc", bus.pc, 0);
        check("reset_sp", bus.sp, 0);
        check("reset_err", bus.stk_err, 0);
        check("reset_valid", bus.addr_valid, 1);
        check("reset_nibble", bus.addr_nibble, 0);

        for (int i = 0; i < 13; i++) begin
            run_instr(vecs[i].v, vecs[i].cmd, vecs[i].la, vecs[i].hold, nibs, m1);
            check($sformatf("v%0d_nibs", i), nibs, vecs[i].nibs);
            check($sformatf("v%0d_pc_m1", i), m1, vecs[i].m1);
            check($sformatf("v%0d_pc", i), bus.pc, vecs[i].pc_end);
            check($sformatf("v%0d_sp", i), bus.sp, vecs[i].sp);
            check($sformatf("v%0d_err", i), bus.stk_err, 0);
        end

        // Four CALLs from sp=0: pointer wraps, slot0 overwritten.
        for (int i = 0; i < 4; i++) begin
            run_instr(1'b1, 3'd2, call_la[i], 1'b0, nibs, m1);
            check($sformatf("call%0d_pc", i), bus.pc, call_la[i]);
            check($sformatf("call%0d_sp", i), bus.sp, (i + 1) % 4);
            check($sformatf("call%0d_err", i), bus.stk_err, (i == 3) ? CHK : 1'b0);
        end
        // Unwind past empty: contents are incremented return addresses.
        for (int i = 0; i < 5; i++) begin
            run_instr(1'b1, 3'd3, 12'h000, 1'b0, nibs, m1);
            check($sformatf("ret%0d_pc", i), bus.pc, ret_pc[i]);
            check($sformatf("ret%0d_sp", i), bus.sp, ret_sp[i]);
            check($sformatf("ret%0d_err", i), bus.stk_err, CHK);
        end

        // Reset with a pending command and a simultaneous cyc_adv at X3.
        bus.icyc      = X2;
        bus.cmd_valid = 1'b1;
        bus.cmd       = JUMP;
        bus.load_addr = 12'h999;
        @(posedge clk); #1;
        bus.icyc    = X3;
        bus.cyc_adv = 1'b1;
        rst         = 1'b1;
        @(posedge clk); #1;
        rst           = 1'b0;
        bus.cyc_adv   = 1'b0;
        bus.cmd_valid = 1'b0;
        check("rst_mid_pc", bus.pc, 0);
        check("rst_mid_sp", bus.sp, 0);
        check("rst_mid_err", bus.stk_err, 0);
        run_instr(1'b0, 3'd0, 12'h000, 1'b0, nibs, m1);
        check("post_rst_nibs", nibs, 12'h000);
        check("post_rst_m1", m1, 12'h001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i4004_addr_stack.md
Name: i4004_addr_stack

Overview:
- Program-counter and subroutine-stack controller for the i4004 core.
- Owns the address register file: DEPTH 12-bit slots plus a slot pointer. The slot under the pointer is the live PC.
- Sequences the three A-cycle address nibbles onto the bus arbiter, increments the PC once per fetch, and executes jump/call/return/fetch-indirect commands issued by the instruction decoder at X3.

Parameters:
- DEPTH, 4, number of address slots (power of two; live PC plus DEPTH-1 return addresses).
- AW, 12, address width in bits (multiple of 4).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous active-high reset.
- icyc  in  3  current instruction subcycle, mcs4::instr_cyc_t: A1=0, A2=1, A3=2, M1=3, M2=4, X1=5, X2=6, X3=7.
- cyc_adv  in  1  one-clk pulse on the last clk of a subcycle (the timing generator's clken_2 phase).
- cmd  in  3  mcs4::stk_cmd_t: NOP, JUMP, CALL, RET, LOAD_LO.
- cmd_valid  in  1  decoder command strobe; sampled only when cyc_adv && icyc==X3.
- load_addr  in  AW  target address for JUMP/CALL; [7:0] used by LOAD_LO.
- inc_hold  in  1  suppresses the A3 increment for this fetch (reserved for the second word of two-word instructions).
- addr_nibble  out  4  PC nibble for the bus arbiter.
- addr_valid  out  1  high while icyc is A1..A3.
- pc  out  AW  live PC (slot[ptr]).
- sp  out  log2(DEPTH)  slot pointer.
- stk_err  out  1  sticky overflow/underflow flag (see Optional Feature).

Behaviour:
- Reset (sync, rst=1 at a clk edge): all slots=0, ptr=0, stk_err=0.
  - Consequences: pc=0, sp=0, addr_valid follows icyc, addr_nibble=0.
  - Reset mid-command discards the command, and reset wins over a simultaneous cyc_adv.
- addr_nibble is combinational from registered state:
  - A1: pc[3:0]; A2: pc[7:4]; A3: pc[11:8].
  - Otherwise 0, with addr_valid=0.
- Increment: on cyc_adv && icyc==A3 && !inc_hold, slot[ptr] <= slot[ptr]+1, modulo 2^AW (0xFFF -> 0x000).
  - The new value is visible from M1; the A-nibbles of the current fetch already show the old PC.
- Commands, executed on cyc_adv && icyc==X3 && cmd_valid. Result is visible at the next A1.
  - NOP: no change.
  - JUMP: slot[ptr] <= load_addr.
  - CALL: ptr <= ptr+1 mod DEPTH; slot[ptr+1] <= load_addr. The old slot keeps the already-incremented return address.
  - RET: ptr <= ptr-1 mod DEPTH. Slot contents are untouched.
  - LOAD_LO: slot[ptr][7:0] <= load_addr[7:0]; [11:8] unchanged.
  - Undefined encodings are treated as NOP.
- cmd_valid outside X3/cyc_adv is ignored. inc_hold outside A3/cyc_adv is ignored.
- Stack wrap: CALL at ptr=DEPTH-1 wraps to 0 and overwrites the oldest return address. RET at ptr=0 wraps to DEPTH-1. Both match 4004 silicon.
- No state change occurs on clks without cyc_adv.
- State machine: none beyond ptr. The sequence is driven entirely by icyc and cyc_adv.
  - The block must tolerate icyc jumping (e.g. timing resync); it acts only on the icyc value present at cyc_adv.

Optional Feature:
- Macro: I4004_STACK_CHK_EN.
- Defined:
  - Tracks depth 0..DEPTH-1 in a separate counter, reset to 0.
  - CALL at depth DEPTH-1, or RET at depth 0, sets stk_err=1.
  - stk_err stays set until rst. Wrap behaviour is unchanged.
- Undefined: no depth counter; stk_err tied 0.

Decomposition:
- Package mcs4 holds:
  - addr_t (12-bit) and instr_cyc_t (existing).
  - New stk_cmd_t enum {NOP=0, JUMP=1, CALL=2, RET=3, LOAD_LO=4}.
  - Localparam STACK_DEPTH=4.
- No sub-module; the incrementer and nibble mux stay inline.

Test Plan:
- Reset then 3 full instruction cycles with cmd NOP -> A1/A2/A3 nibbles 0,0,0; pc steps 0x000 -> 0x001 -> 0x002 -> 0x003, each change visible at M1.
- Preload pc=0xFFF via JUMP, run one fetch -> nibbles F,F,F; pc becomes 0x000 at M1.
- pc=0x123, CALL load_addr=0x5A0 at X3 -> next A1 nibbles 0,A,5; sp=1; after RET at X3, pc=0x124 (incremented return), sp=0.
- Four CALLs from sp=0 -> sp wraps 3 -> 0; slot0 overwritten. With I4004_STACK_CHK_EN, stk_err=1 after the fourth CALL and stays set; without it, stk_err stays 0.
- pc=0x3F7, LOAD_LO load_addr=0xAB2 -> pc=0x3B2. Then a fetch with inc_hold=1 at A3 -> pc stays 0x3B2.
- Assert rst during X2 with cmd_valid=1 pending -> pc=0, sp=0, stk_err=0, and the pending command has no effect.
